// File: rtl/mac_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_serializer
// Brief    : Queues MAC results in a small FIFO and shifts each one out
//            MSB-first on a single pad, framed by a strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mac_result_serializer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clken,
    input  logic [DATA_W-1:0]        res_in,
    input  logic                     res_valid,
    input  logic                     ser_en,
    input  logic                     clr_ovf,
    output logic                     sout,
    output logic                     sframe,
    output logic                     busy,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_BIT_W = $clog2(DATA_W);
    localparam int c_PH_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(BIT_CYCLES - 1);
    localparam logic [c_PH_W-1:0]  c_PH_ONE   = c_PH_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [1:0]         r_state;
    logic [c_BIT_W-1:0] r_bit;
    logic [c_PH_W-1:0]  r_phase;
    // Holds only the bits still to be sent; the current bit lives in r_sout.
    logic [DATA_W-2:0]  r_shreg;
    logic               r_sout;
    logic               r_sframe;
    logic               r_overflow;

    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_drop;

    assign w_pop      = clken && (r_state == c_LOAD);
    assign w_push_req = clken && res_valid;
    // A full FIFO still takes a word when the head is leaving this very cycle.
    assign w_push     = w_push_req && ((r_count != c_FULL) || w_pop);
    assign w_drop     = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= res_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= c_IDLE;
            r_bit      <= '0;
            r_phase    <= '0;
            r_shreg    <= '0;
            r_sout     <= 1'b0;
            r_sframe   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clken) begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    r_sout   <= 1'b0;
                    r_sframe <= 1'b0;
                    if ((r_count != '0) && ser_en) begin
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_sout   <= r_mem[r_rd_ptr][DATA_W-1];
                    r_shreg  <= r_mem[r_rd_ptr][DATA_W-2:0];
                    r_sframe <= 1'b1;
                    r_bit    <= '0;
                    r_phase  <= '0;
                    r_state  <= c_SHIFT;
                end
                c_SHIFT: begin
                    if (r_phase == c_PH_LAST) begin
                        r_phase <= '0;
                        if (r_bit == c_BIT_LAST) begin
                            r_sout   <= 1'b0;
                            r_sframe <= 1'b0;
                            r_state  <= c_STOP;
                        end else begin
                            r_bit   <= r_bit + c_BIT_ONE;
                            r_sout  <= r_shreg[DATA_W-2];
                            r_shreg <= r_shreg << 1;
                        end
                    end else begin
                        r_phase <= r_phase + c_PH_ONE;
                    end
                end
                c_STOP: begin
                    if (r_phase == c_PH_LAST) begin
                        r_phase <= '0;
                        if ((r_count != '0) && ser_en) begin
                            r_state <= c_LOAD;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_phase <= r_phase + c_PH_ONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign sout       = r_sout;
    assign sframe     = r_sframe;
    assign busy       = (r_state != c_IDLE);
    assign fifo_full  = (r_count == c_FULL);
    assign fifo_empty = (r_count == '0);
    assign overflow   = r_overflow;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mac_result_serializer
// Brief    : Directed scoreboard bench; instance a uses BIT_CYCLES=1,
//            instance b uses BIT_CYCLES=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_result_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_clken, a_valid, a_ser_en, a_clr;
    logic [15:0] a_res;
    logic        a_sout, a_sframe, a_busy, a_full, a_empty, a_ovf;
    logic [2:0]  a_count;

    logic        b_rst, b_clken, b_valid, b_ser_en, b_clr;
    logic [15:0] b_res;
    logic        b_sout, b_sframe, b_busy, b_full, b_empty, b_ovf;
    logic [2:0]  b_count;

    mac_result_serializer #(.DATA_W(16), .DEPTH(4), .BIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(a_rst), .clken(a_clken), .res_in(a_res),
        .res_valid(a_valid), .ser_en(a_ser_en), .clr_ovf(a_clr),
        .sout(a_sout), .sframe(a_sframe), .busy(a_busy), .fifo_full(a_full),
        .fifo_empty(a_empty), .overflow(a_ovf), .count(a_count)
    );

    mac_result_serializer #(.DATA_W(16), .DEPTH(4), .BIT_CYCLES(2)) u_dut_b (
        .clk(clk), .rst(b_rst), .clken(b_clken), .res_in(b_res),
        .res_valid(b_valid), .ser_en(b_ser_en), .clr_ovf(b_clr),
        .sout(b_sout), .sframe(b_sframe), .busy(b_busy), .fifo_full(b_full),
        .fifo_empty(b_empty), .overflow(b_ovf), .count(b_count)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: rebuilds each frame from enabled-cycle samples and checks
    // frame length, per-bit hold consistency and busy-run length.
    logic [1:0]  m_rst, m_clken, m_sout, m_sframe, m_busy;
    assign m_rst    = {b_rst, a_rst};
    assign m_clken  = {b_clken, a_clken};
    assign m_sout   = {b_sout, a_sout};
    assign m_sframe = {b_sframe, a_sframe};
    assign m_busy   = {b_busy, a_busy};

    int          nsamp[2];
    int          run[2];
    int          frames[2];
    logic        bad[2];
    logic        cur[2];
    logic [15:0] word[2];
    logic [15:0] mon_exp;
    logic        mon_have;

    initial begin
        for (int k = 0; k < 2; k++) begin
            nsamp[k] = 0; run[k] = 0; frames[k] = 0;
            bad[k] = 1'b0; cur[k] = 1'b0; word[k] = '0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int bc;
            bc = (k == 0) ? 1 : 2;
            if (m_rst[k]) begin
                nsamp[k] = 0; run[k] = 0; frames[k] = 0; bad[k] = 1'b0; word[k] = '0;
            end else if (m_clken[k]) begin
                if (m_sframe[k]) begin
                    if (nsamp[k] % bc == 0) begin
                        word[k] = {word[k][14:0], m_sout[k]};
                        cur[k]  = m_sout[k];
                    end else if (m_sout[k] != cur[k]) begin
                        bad[k] = 1'b1;
                    end
                    nsamp[k]++;
                end else if (nsamp[k] > 0) begin
                    chk($sformatf("frame_len%0d", k), nsamp[k], 16 * bc);
                    mon_have = 1'b0;
                    mon_exp  = '0;
                    if (k == 0 && q0.size() > 0) begin
                        mon_exp = q0.pop_front(); mon_have = 1'b1;
                    end else if (k == 1 && q1.size() > 0) begin
                        mon_exp = q1.pop_front(); mon_have = 1'b1;
                    end
                    if (mon_have) begin
                        chk($sformatf("frame_word%0d", k), {15'd0, bad[k], word[k]}, {16'd0, mon_exp});
                    end else begin
                        n_vec++;
                        n_err++;
                        $display("FAIL frame_word%0d: got %h expected no frame", k, word[k]);
                    end
                    frames[k]++;
                    nsamp[k] = 0;
                    bad[k]   = 1'b0;
                end
                if (m_busy[k]) begin
                    run[k]++;
                end else if (run[k] > 0) begin
                    chk($sformatf("busy_run%0d", k), run[k], frames[k] * (1 + 16 * bc + bc));
                    run[k]    = 0;
                    frames[k] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [15:0] w, input logic acc);
        a_res = w; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        if (acc) q0.push_back(w);
    endtask

    task automatic push_b(input logic [15:0] w, input logic acc);
        b_res = w; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        if (acc) q1.push_back(w);
    endtask

    task automatic wait_idle(input int k, input string nm);
        tick(); tick();
        for (int i = 0; i < 400; i++) begin
            if ((k == 0) ? !a_busy : !b_busy) break;
            tick();
        end
        chk(nm, (k == 0) ? a_busy : b_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        a_rst = 1'b1; a_clken = 1'b1; a_valid = 1'b0; a_ser_en = 1'b0; a_clr = 1'b0; a_res = '0;
        b_rst = 1'b1; b_clken = 1'b1; b_valid = 1'b0; b_ser_en = 1'b0; b_clr = 1'b0; b_res = '0;
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;
        tick();

        chk("rst_sout", a_sout, 0);
        chk("rst_sframe", a_sframe, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_full", a_full, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_count", a_count, 0);
        chk("rst_b_empty", b_empty, 1);

        // Single frame and first-bit latency
        a_ser_en = 1'b1;
        push_a(16'hA5C3, 1'b1);
        chk("lat_count", a_count, 1);
        chk("lat_busy0", a_busy, 0);
        tick();
        chk("lat_load_busy", a_busy, 1);
        chk("lat_load_sframe", a_sframe, 0);
        tick();
        chk("lat_first_sframe", a_sframe, 1);
        chk("lat_first_sout", a_sout, 1);
        wait_idle(0, "single_idle");
        chk("single_count", a_count, 0);

        // Overflow, then push while full during LOAD
        a_ser_en = 1'b0;
        push_a(16'h0001, 1'b1);
        push_a(16'h0002, 1'b1);
        push_a(16'h0003, 1'b1);
        push_a(16'h0004, 1'b1);
        push_a(16'h0005, 1'b0);
        chk("ovf_count", a_count, 4);
        chk("ovf_full", a_full, 1);
        chk("ovf_flag", a_ovf, 1);
        chk("ovf_empty", a_empty, 0);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("ovf_cleared", a_ovf, 0);
        a_ser_en = 1'b1;
        tick();
        chk("load_busy", a_busy, 1);
        push_a(16'hBEEF, 1'b1);
        chk("load_push_count", a_count, 4);
        chk("load_push_ovf", a_ovf, 0);
        chk("load_push_full", a_full, 1);
        wait_idle(0, "ovf_idle");
        chk("ovf_drain_empty", a_empty, 1);

        // clken gating on the BIT_CYCLES=2 instance
        w = 16'h6CAB;
        b_ser_en = 1'b1;
        push_b(w, 1'b1);
        tick(); tick();
        repeat (16) tick();
        chk("gate_bit7_pre", b_sout, {31'd0, w[7]});
        b_clken = 1'b0;
        b_res   = 16'hFFFF;
        b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gate_sout", b_sout, {31'd0, w[7]});
            chk("gate_sframe", b_sframe, 1);
            chk("gate_count", b_count, 0);
            chk("gate_busy", b_busy, 1);
        end
        b_valid = 1'b0;
        b_clken = 1'b1;
        wait_idle(1, "gate_idle");
        chk("gate_count_end", b_count, 0);

        // Reset in the middle of a frame with two words still queued
        a_ser_en = 1'b0;
        push_a(16'h1111, 1'b1);
        push_a(16'h2222, 1'b1);
        push_a(16'h3333, 1'b1);
        a_ser_en = 1'b1;
        tick(); tick();
        repeat (6) tick();
        chk("mid_count", a_count, 2);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        q0.delete();
        chk("mrst_sout", a_sout, 0);
        chk("mrst_sframe", a_sframe, 0);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_count", a_count, 0);
        chk("mrst_empty", a_empty, 1);
        push_a(16'h8001, 1'b1);
        wait_idle(0, "mrst_idle");

        // ser_en dropped mid-frame
        a_ser_en = 1'b0;
        push_a(16'h1234, 1'b1);
        push_a(16'h5678, 1'b1);
        a_ser_en = 1'b1;
        tick(); tick();
        repeat (3) tick();
        a_ser_en = 1'b0;
        wait_idle(0, "seren_idle");
        chk("seren_count", a_count, 1);
        repeat (3) tick();
        chk("seren_hold_busy", a_busy, 0);
        chk("seren_hold_count", a_count, 1);
        a_ser_en = 1'b1;
        wait_idle(0, "seren_resume_idle");
        chk("seren_final_count", a_count, 0);

        repeat (3) tick();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
